// File: rtl/seq_mult_param.sv
// Sequential WIDTHxWIDTH multiplier accumulating one DIGITxDIGIT partial product per clock.
// Optional two's-complement operands when SEQ_MULT_SIGNED_EN is defined (adds signed_op port).
module seq_mult_param #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 4
) (
    input  logic               clk,
    input  logic               aclr_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   dataa,
    input  logic [WIDTH-1:0]   datab,
`ifdef SEQ_MULT_SIGNED_EN
    input  logic               signed_op,
`endif
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [2:0]         state_out,
    output logic [2*WIDTH-1:0] product
);
    localparam int ND    = WIDTH / DIGIT;
    localparam int STEPS = ND * ND;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int PW    = 2 * WIDTH;
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    generate
        if (WIDTH % DIGIT != 0) begin : g_bad_digit
            $error("seq_mult_param: WIDTH must be a multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE = 3'b000,
        CALC = 3'b001,
        DONE = 3'b010,
        ERR  = 3'b011
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [PW-1:0]    product_q, product_d, sum_d;
    logic [WIDTH-1:0] a_in, b_in;
    logic [CW-1:0]    di, dj;
    logic [DIGIT-1:0] da, db;
    logic [2*DIGIT-1:0] pp;

    // Operands are stored as magnitudes; the sign is reapplied on the final step.
`ifdef SEQ_MULT_SIGNED_EN
    logic sign_q, sign_in;
    always_comb begin
        a_in    = (signed_op && dataa[WIDTH-1]) ? -dataa : dataa;
        b_in    = (signed_op && datab[WIDTH-1]) ? -datab : datab;
        sign_in = signed_op && (dataa[WIDTH-1] ^ datab[WIDTH-1]);
    end
`else
    assign a_in = dataa;
    assign b_in = datab;
`endif

    always_comb begin
        di        = cnt_q / CW'(ND);
        dj        = cnt_q % CW'(ND);
        da        = DIGIT'(a_q >> (DIGIT * int'(di)));
        db        = DIGIT'(b_q >> (DIGIT * int'(dj)));
        pp        = (2*DIGIT)'(da) * (2*DIGIT)'(db);
        sum_d     = product_q + (PW'(pp) << (DIGIT * (int'(di) + int'(dj))));
        product_d = sum_d;
`ifdef SEQ_MULT_SIGNED_EN
        if (sign_q && (cnt_q == LAST)) product_d = -sum_d;
`endif
        cnt_d     = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            cnt_q     <= '0;
            product_q <= '0;
`ifdef SEQ_MULT_SIGNED_EN
            sign_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        a_q       <= a_in;
                        b_q       <= b_in;
`ifdef SEQ_MULT_SIGNED_EN
                        sign_q    <= sign_in;
`endif
                        cnt_q     <= '0;
                        product_q <= '0;
                        state_q   <= CALC;
                    end else begin
                        state_q   <= IDLE;
                    end
                end
                CALC: begin
                    // A start still held on the first CALC edge is the tail of the accepting request.
                    if (start && (cnt_q != '0)) begin
                        state_q <= ERR;
                    end else begin
                        product_q <= product_d;
                        cnt_q     <= cnt_d;
                        if (cnt_q == LAST) state_q <= DONE;
                    end
                end
                ERR: begin
                    if (!start) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = (state_q == CALC);
    assign done      = (state_q == DONE);
    assign err       = (state_q == ERR);
    assign state_out = state_q;
    assign product   = product_q;
endmodule

// File: tb/tb_seq_mult_param.sv
// Self-checking bench for seq_mult_param: W8/D4 and W16/D4 instances against an arithmetic model.
module tb_seq_mult_param;
    logic clk = 1'b0;
    logic aclr_n = 1'b0;
    always #5 clk = ~clk;

    logic        start8 = 1'b0, start16 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        busy8, done8, err8, busy16, done16, err16;
    logic [2:0]  st8, st16;
    logic [15:0] p8;
    logic [31:0] p16;
`ifdef SEQ_MULT_SIGNED_EN
    logic        sop8 = 1'b0, sop16 = 1'b0;
`endif

    seq_mult_param #(.WIDTH(8), .DIGIT(4)) u_w8 (
        .clk(clk), .aclr_n(aclr_n), .start(start8), .dataa(a8), .datab(b8),
`ifdef SEQ_MULT_SIGNED_EN
        .signed_op(sop8),
`endif
        .busy(busy8), .done(done8), .err(err8), .state_out(st8), .product(p8)
    );

    seq_mult_param #(.WIDTH(16), .DIGIT(4)) u_w16 (
        .clk(clk), .aclr_n(aclr_n), .start(start16), .dataa(a16), .datab(b16),
`ifdef SEQ_MULT_SIGNED_EN
        .signed_op(sop16),
`endif
        .busy(busy16), .done(done16), .err(err16), .state_out(st16), .product(p16)
    );

    bit          sel16 = 1'b0;
    logic        o_busy, o_done, o_err;
    logic [2:0]  o_st;
    logic [31:0] o_prod;
    assign o_busy = sel16 ? busy16 : busy8;
    assign o_done = sel16 ? done16 : done8;
    assign o_err  = sel16 ? err16  : err8;
    assign o_st   = sel16 ? st16   : st8;
    assign o_prod = sel16 ? p16    : {16'h0, p8};

    int checks = 0;
    int passed = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_start(input bit v);
        if (sel16) start16 = v; else start8 = v;
    endtask

    // Plain-arithmetic reference: interpret operands, multiply, keep 2*w bits.
    function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input bit sop, input int w);
        longint x, y, m;
        x = longint'(a);
        y = longint'(b);
        if (sop && a[w-1]) x = x - (longint'(1) << w);
        if (sop && b[w-1]) y = y - (longint'(1) << w);
        m = (longint'(1) << (2 * w)) - 1;
        return 32'((x * y) & m);
    endfunction

    task automatic launch(input logic [15:0] a, input logic [15:0] b, input bit sop, input bit hold);
        if (sel16) begin a16 = a; b16 = b; end
        else begin a8 = a[7:0]; b8 = b[7:0]; end
`ifdef SEQ_MULT_SIGNED_EN
        if (sel16) sop16 = sop; else sop8 = sop;
`endif
        set_start(1'b1);
        step();
        if (hold) step();
        set_start(1'b0);
        if (sel16) begin a16 = 16'($urandom); b16 = 16'($urandom); end
        else begin a8 = 8'($urandom); b8 = 8'($urandom); end
    endtask

    task automatic finish(input logic [31:0] exp, input string tag, input bit hold);
        int cyc, nbusy, steps;
        cyc = 0;
        nbusy = 0;
        steps = sel16 ? 16 : 4;
        while (!o_done && cyc < 200) begin
            if (o_busy) nbusy++;
            step();
            cyc++;
        end
        chk({tag, " latency"}, 32'(cyc), 32'(steps - int'(hold)));
        chk({tag, " busy_cycles"}, 32'(nbusy), 32'(steps - int'(hold)));
        chk({tag, " product"}, o_prod, exp);
    endtask

    task automatic after_done(input logic [31:0] exp, input string tag);
        step();
        chk({tag, " done_once"}, 32'(o_done), 32'd0);
        chk({tag, " idle"}, 32'(o_st), 32'd0);
        chk({tag, " hold"}, o_prod, exp);
    endtask

    initial begin
        logic [15:0] ra, rb;
        logic [31:0] e, pfz;
        bit hold;

        #2;
        chk("reset state8", 32'(st8), 32'd0);
        chk("reset prod8", {16'h0, p8}, 32'd0);
        chk("reset flags8", {29'd0, busy8, done8, err8}, 32'd0);
        chk("reset state16", 32'(st16), 32'd0);
        chk("reset prod16", p16, 32'd0);
        @(posedge clk);
        #1 aclr_n = 1'b1;

        // W8 directed vectors
        sel16 = 1'b0;
        launch(16'h00FF, 16'h00FF, 1'b0, 1'b0);
        chk("ff busy", 32'(o_busy), 32'd1);
        finish(32'h0000_FE01, "ffxff", 1'b0);
        after_done(32'h0000_FE01, "ffxff");
        launch(16'h0000, 16'h00AB, 1'b0, 1'b0);
        finish(32'h0, "0xab", 1'b0);
        after_done(32'h0, "0xab");
        launch(16'h0012, 16'h0034, 1'b0, 1'b0);
        finish(32'h0000_03A8, "12x34", 1'b0);
        after_done(32'h0000_03A8, "12x34");

        // Abort: start reasserted on the second CALC edge
        launch(16'h005A, 16'h00C3, 1'b0, 1'b0);
        step();
        set_start(1'b1);
        step();
        chk("err state", 32'(o_st), 32'd3);
        chk("err flag", 32'(o_err), 32'd1);
        chk("err busy", 32'(o_busy), 32'd0);
        pfz = o_prod;
        step();
        chk("err stay", 32'(o_st), 32'd3);
        chk("err frozen", o_prod, pfz);
        set_start(1'b0);
        step();
        chk("err exit idle", 32'(o_st), 32'd0);
        chk("err no done", 32'(o_done), 32'd0);
        step();
        chk("err no done late", 32'(o_done), 32'd0);

        // Asynchronous reset during CALC
        launch(16'h0077, 16'h0099, 1'b0, 1'b0);
        step();
        step();
        #2 aclr_n = 1'b0;
        #1;
        chk("arst state", 32'(o_st), 32'd0);
        chk("arst prod", o_prod, 32'd0);
        chk("arst flags", {29'd0, o_busy, o_done, o_err}, 32'd0);
        @(posedge clk);
        #1 aclr_n = 1'b1;
        chk("arst no done", 32'(o_done), 32'd0);
        launch(16'h00C5, 16'h003E, 1'b0, 1'b0);
        finish(model(16'h00C5, 16'h003E, 1'b0, 8), "post_rst", 1'b0);
        after_done(model(16'h00C5, 16'h003E, 1'b0, 8), "post_rst");

        // Random W8 operations, sometimes holding start into the first CALC edge
        for (int k = 0; k < 12; k++) begin
            ra = 16'($urandom_range(0, 255));
            rb = 16'($urandom_range(0, 255));
            hold = 1'($urandom_range(0, 1));
            e = model(ra, rb, 1'b0, 8);
            launch(ra, rb, 1'b0, hold);
            finish(e, "rand8", hold);
            after_done(e, "rand8");
        end

        // W16: full-scale then back-to-back acceptance from DONE
        sel16 = 1'b1;
        launch(16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
        finish(32'hFFFE_0001, "w16 ffff", 1'b0);
        ra = 16'h1234;
        rb = 16'hABCD;
        a16 = ra;
        b16 = rb;
        set_start(1'b1);
        step();
        set_start(1'b0);
        chk("b2b calc", 32'(o_st), 32'd1);
        chk("b2b cleared", o_prod, 32'd0);
        finish(model(ra, rb, 1'b0, 16), "w16 b2b", 1'b0);
        after_done(model(ra, rb, 1'b0, 16), "w16 b2b");
        for (int k = 0; k < 6; k++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            e = model(ra, rb, 1'b0, 16);
            launch(ra, rb, 1'b0, 1'b0);
            finish(e, "rand16", 1'b0);
            after_done(e, "rand16");
        end

`ifdef SEQ_MULT_SIGNED_EN
        sel16 = 1'b0;
        launch(16'h0080, 16'h007F, 1'b1, 1'b0);
        finish(32'h0000_C080, "s -128x127", 1'b0);
        after_done(32'h0000_C080, "s -128x127");
        launch(16'h00FF, 16'h00FF, 1'b1, 1'b0);
        finish(32'h0000_0001, "s -1x-1", 1'b0);
        after_done(32'h0000_0001, "s -1x-1");
        launch(16'h0080, 16'h007F, 1'b0, 1'b0);
        finish(32'h0000_3F80, "u 80x7f", 1'b0);
        after_done(32'h0000_3F80, "u 80x7f");
        for (int k = 0; k < 6; k++) begin
            sel16 = 1'(k % 2);
            ra = sel16 ? 16'($urandom) : 16'($urandom_range(0, 255));
            rb = sel16 ? 16'($urandom) : 16'($urandom_range(0, 255));
            e = model(ra, rb, 1'b1, sel16 ? 16 : 8);
            launch(ra, rb, 1'b1, 1'b0);
            finish(e, "srand", 1'b0);
            after_done(e, "srand");
        end
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
